// File: rtl/rq_scheduler.sv
// Shared-request-line scheduler: synchronizes per-channel strobes, divides them down,
// and issues round-robin RQ pulses of programmable width separated by a fixed gap.
module rq_scheduler #(
  parameter int NCH = 4,
  parameter int GAP = 2
) (
  input  logic           clk80MHz,
  input  logic           rst,
  input  logic [NCH-1:0] val,
  input  logic [NCH-1:0] en,
  input  logic [1:0]     div_cfg,
  input  logic [4:0]     width_cfg,
  input  logic           clr_ovf,
  output logic           RQ,
  output logic [1:0]     rq_id,
  output logic           busy,
  output logic [NCH-1:0] ovf
);

  typedef enum logic [1:0] {IDLE, PULSE, SPACE} state_t;

  logic [NCH-1:0] val_p0, val_p1, val_p2;
  logic [NCH-1:0] stb_rise, comp, ovf_set, req, grant, pend;
  logic [1:0]     cnt [NCH];

  state_t      state_q, state_d;
  logic [4:0]  pcnt_q, pcnt_d, width_q, width_d;
  logic [2:0]  gcnt_q, gcnt_d;
  logic [1:0]  last_grant, last_grant_d, rq_id_d, win, cand;
  logic        win_vld, try_grant;

  // Stage p0/p1: two-flop synchronizer; p2: history flop for rising-edge detect
  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      val_p0 <= '0;
      val_p1 <= '0;
      val_p2 <= '0;
    end else begin
      val_p0 <= val;
      val_p1 <= val_p0;
      val_p2 <= val_p1;
    end
  end

  always_comb begin
    stb_rise = val_p1 & ~val_p2;
    comp     = '0;
    ovf_set  = '0;
    for (int i = 0; i < NCH; i++) begin
      comp[i]    = en[i] & stb_rise[i] & (cnt[i] >= div_cfg);
      // A grant retiring the old request absorbs a simultaneous new completion
      ovf_set[i] = comp[i] & pend[i] & ~grant[i];
    end
  end

  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      pend <= '0;
      ovf  <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      ovf <= (clr_ovf ? '0 : ovf) | ovf_set;
      for (int i = 0; i < NCH; i++) begin
        if (!en[i]) begin
          cnt[i]  <= '0;
          pend[i] <= 1'b0;
        end else begin
          if (stb_rise[i]) cnt[i] <= comp[i] ? 2'd0 : cnt[i] + 2'd1;
          if (comp[i])       pend[i] <= 1'b1;
          else if (grant[i]) pend[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pick: descending scan so the nearest channel after last_grant wins
  always_comb begin
    req     = pend & en;
    win_vld = 1'b0;
    win     = last_grant;
    cand    = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    gcnt_d       = gcnt_q;
    width_d      = width_q;
    rq_id_d      = rq_id;
    last_grant_d = last_grant;
    grant        = '0;
    try_grant    = 1'b0;
    case (state_q)
      IDLE:  try_grant = 1'b1;
      PULSE: begin
        if (pcnt_q == width_q) begin
          state_d = SPACE;
          gcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 5'd1;
        end
      end
      SPACE: begin
        // Last gap cycle arbitrates directly so RQ stays low exactly GAP cycles
        if (gcnt_q == 3'(GAP - 1)) begin
          state_d   = IDLE;
          try_grant = 1'b1;
        end else begin
          gcnt_d = gcnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (try_grant && win_vld) begin
      state_d      = PULSE;
      pcnt_d       = '0;
      width_d      = width_cfg;
      rq_id_d      = win;
      last_grant_d = win;
      grant[win]   = 1'b1;
    end
  end

  always_ff @(posedge clk80MHz) begin
    if (rst) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      gcnt_q     <= '0;
      width_q    <= '0;
      last_grant <= 2'd3;
      rq_id      <= '0;
      RQ         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      gcnt_q     <= gcnt_d;
      width_q    <= width_d;
      last_grant <= last_grant_d;
      rq_id      <= rq_id_d;
      RQ         <= (state_d == PULSE);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_rq_scheduler.sv
// Directed self-checking bench for rq_scheduler: dividers, round-robin, overflow,
// reset behaviour and enable gating.
`timescale 1ns/1ps
module tb_rq_scheduler;

  logic       clk80MHz = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] val = '0;
  logic [3:0] en = '0;
  logic [1:0] div_cfg = '0;
  logic [4:0] width_cfg = '0;
  logic       clr_ovf = 1'b0;
  logic       RQ;
  logic [1:0] rq_id;
  logic       busy;
  logic [3:0] ovf;

  int n_chk = 0;
  int n_fail = 0;
  int rq_rises = 0;

  rq_scheduler #(.NCH(4), .GAP(2)) dut (
    .clk80MHz (clk80MHz),
    .rst      (rst),
    .val      (val),
    .en       (en),
    .div_cfg  (div_cfg),
    .width_cfg(width_cfg),
    .clr_ovf  (clr_ovf),
    .RQ       (RQ),
    .rq_id    (rq_id),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #6.25 clk80MHz = ~clk80MHz;
  always @(posedge RQ) rq_rises++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk80MHz);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; val = '0; en = '0; clr_ovf = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();
  endtask

  task automatic strobe(input int ch);
    val[ch] = 1'b1;
    ticks(2);
    val[ch] = 1'b0;
    ticks(2);
  endtask

  task automatic wait_rise(input int budget, output int n);
    n = 0;
    while (RQ !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic high_len(output int n);
    n = 0;
    while (RQ === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic low_len(output int n);
    n = 0;
    while (RQ === 1'b0 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; val = '0; en = '0;
    ticks(2);
    n_chk++; if (RQ !== 1'b0) begin n_fail++; $display("FAIL reset_rq: got %b expected 0", RQ); end
    n_chk++; if (rq_id !== 2'd0) begin n_fail++; $display("FAIL reset_rq_id: got %0d expected 0", rq_id); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0000", ovf); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divider();
    int n, len, r0;
    do_reset();
    div_cfg = 2'd3; width_cfg = 5'd31; en = 4'b0001;
    r0 = rq_rises;
    for (int i = 0; i < 3; i++) strobe(0);
    ticks(8);
    n_chk++; if (rq_rises - r0 !== 0) begin n_fail++; $display("FAIL div_early_grant: got %0d pulses expected 0", rq_rises - r0); end
    val[0] = 1'b1;
    wait_rise(20, n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL div_latency: got %0d cycles expected 4", n); end
    n_chk++; if (rq_id !== 2'd0) begin n_fail++; $display("FAIL div_rq_id: got %0d expected 0", rq_id); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy: got %b expected 1", busy); end
    val[0] = 1'b0;
    high_len(len);
    n_chk++; if (len !== 32) begin n_fail++; $display("FAIL div_width: got %0d cycles expected 32", len); end
    ticks(60);
    n_chk++; if (rq_rises - r0 !== 1) begin n_fail++; $display("FAIL div_pulse_count: got %0d expected 1", rq_rises - r0); end
  endtask

  task automatic test_round_robin();
    int n, len;
    do_reset();
    div_cfg = 2'd0; width_cfg = 5'd3; en = 4'b1111;
    val = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      wait_rise(40, n);
      n_chk++; if (n >= 40) begin n_fail++; $display("FAIL rr_rise_timeout: got %0d cycles expected <40", n); end
      n_chk++; if (rq_id !== 2'(p)) begin n_fail++; $display("FAIL rr_order: got %0d expected %0d", rq_id, p); end
      high_len(len);
      n_chk++; if (len !== 4) begin n_fail++; $display("FAIL rr_width: got %0d expected 4", len); end
      if (p < 3) begin
        low_len(len);
        n_chk++; if (len !== 2) begin n_fail++; $display("FAIL rr_gap: got %0d expected 2", len); end
      end
    end
    val = '0;
    ticks(10);
    n_chk++; if (rq_id !== 2'd3) begin n_fail++; $display("FAIL rr_id_hold: got %0d expected 3", rq_id); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overflow();
    int n, len, r0;
    do_reset();
    div_cfg = 2'd0; width_cfg = 5'd31; en = 4'b0101;
    val[0] = 1'b1;
    wait_rise(20, n);
    val[0] = 1'b0;
    n_chk++; if (rq_id !== 2'd0) begin n_fail++; $display("FAIL ovf_first_id: got %0d expected 0", rq_id); end
    strobe(2);
    strobe(2);
    n_chk++; if (ovf !== 4'b0100) begin n_fail++; $display("FAIL ovf_set: got %b expected 0100", ovf); end
    strobe(2);
    n_chk++; if (ovf !== 4'b0100) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 0100", ovf); end
    high_len(len);
    n_chk++; if (12 + len !== 32) begin n_fail++; $display("FAIL ovf_long_width: got %0d expected 32", 12 + len); end
    r0 = rq_rises;
    wait_rise(10, n);
    n_chk++; if (n !== 2) begin n_fail++; $display("FAIL ovf_gap: got %0d expected 2", n); end
    n_chk++; if (rq_id !== 2'd2) begin n_fail++; $display("FAIL ovf_ch2_id: got %0d expected 2", rq_id); end
    high_len(len);
    n_chk++; if (len !== 32) begin n_fail++; $display("FAIL ovf_ch2_width: got %0d expected 32", len); end
    ticks(60);
    n_chk++; if (rq_rises - r0 !== 1) begin n_fail++; $display("FAIL ovf_single_ch2: got %0d pulses expected 1", rq_rises - r0); end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_chk++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0000", ovf); end
  endtask

  task automatic test_reset_mid_pulse();
    int n, r0;
    do_reset();
    div_cfg = 2'd0; width_cfg = 5'd31; en = 4'b0011;
    val[0] = 1'b1;
    wait_rise(20, n);
    val[0] = 1'b0;
    strobe(1);
    ticks(5);
    rst = 1'b1;
    tick();
    n_chk++; if (RQ !== 1'b0) begin n_fail++; $display("FAIL midrst_rq: got %b expected 0", RQ); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    rst = 1'b0;
    r0 = rq_rises;
    ticks(60);
    n_chk++; if (rq_rises - r0 !== 0) begin n_fail++; $display("FAIL midrst_no_resume: got %0d pulses expected 0", rq_rises - r0); end
  endtask

  task automatic test_val_through_reset();
    int n, len, r0;
    rst = 1'b1; en = 4'b0001; div_cfg = 2'd0; width_cfg = 5'd3;
    val = 4'b0001;
    ticks(4);
    r0 = rq_rises;
    rst = 1'b0;
    wait_rise(20, n);
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL hold_latency: got %0d expected 4", n); end
    high_len(len);
    n_chk++; if (len !== 4) begin n_fail++; $display("FAIL hold_width: got %0d expected 4", len); end
    ticks(40);
    n_chk++; if (rq_rises - r0 !== 1) begin n_fail++; $display("FAIL hold_single_edge: got %0d pulses expected 1", rq_rises - r0); end
    val = '0;
  endtask

  task automatic test_enable_gating();
    int n, r0;
    do_reset();
    div_cfg = 2'd1; width_cfg = 5'd3; en = 4'b1101;
    r0 = rq_rises;
    for (int i = 0; i < 3; i++) strobe(1);
    ticks(6);
    n_chk++; if (rq_rises - r0 !== 0) begin n_fail++; $display("FAIL en_disabled_grant: got %0d pulses expected 0", rq_rises - r0); end
    en = 4'b1111;
    strobe(1);
    ticks(6);
    n_chk++; if (rq_rises - r0 !== 0) begin n_fail++; $display("FAIL en_first_edge: got %0d pulses expected 0", rq_rises - r0); end
    val[1] = 1'b1;
    wait_rise(20, n);
    val[1] = 1'b0;
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL en_second_edge_latency: got %0d expected 4", n); end
    n_chk++; if (rq_id !== 2'd1) begin n_fail++; $display("FAIL en_rq_id: got %0d expected 1", rq_id); end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_round_robin();
    test_overflow();
    test_reset_mid_pulse();
    test_val_through_reset();
    test_enable_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
